// File: rtl/usr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : usr_cmd_sequencer
// Purpose : Queues shift-register commands and issues one per tick slot,
//           tracking the downstream register contents in shadow_q.
// Revision: 1.0 - initial release
// ============================================================================
module usr_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [3:0]               cmd_data,
    input  logic                     cmd_si,
    output logic [1:0]               M,
    output logic [3:0]               D,
    output logic                     SI,
    output logic                     issue,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [3:0]               shadow_q
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] C_TICK_MAX = TW'(TICK_DIV - 1);

    logic [6:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_m;
    logic [3:0]    r_d;
    logic          r_si;
    logic          r_issue;
    logic [3:0]    r_shadow;

    logic          w_tick;
    logic          w_push;
    logic          w_pop;
    logic [6:0]    w_head;

    // Readiness looks only at the registered count so it never waits on a pop.
    assign cmd_ready = (r_count < C_DEPTH) && !rst;
    assign w_tick    = (r_tick == C_TICK_MAX);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = w_tick && (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_mode, cmd_data, cmd_si};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tick   <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + TW'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue bus is zero outside the single cycle that follows a pop.
    always_ff @(posedge clk) begin
        if (rst || !w_pop) begin
            r_m     <= 2'b00;
            r_d     <= 4'b0000;
            r_si    <= 1'b0;
            r_issue <= 1'b0;
        end else begin
            r_m     <= w_head[6:5];
            r_d     <= w_head[4:1];
            r_si    <= w_head[0];
            r_issue <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= 4'b0000;
        end else if (r_issue) begin
            case (r_m)
                2'b01:   r_shadow <= r_d;
                2'b10:   r_shadow <= {r_shadow[2:0], r_shadow[3]};
                2'b11:   r_shadow <= {r_si, r_shadow[3:1]};
                default: r_shadow <= r_shadow;
            endcase
        end
    end

    assign M          = r_m;
    assign D          = r_d;
    assign SI         = r_si;
    assign issue      = r_issue;
    assign fifo_count = r_count;
    assign shadow_q   = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_usr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_usr_cmd_sequencer
// Purpose : Directed self-checking bench for usr_cmd_sequencer (DEPTH=4, TICK_DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_usr_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic       cmd_si;
    logic [1:0] m;
    logic [3:0] d;
    logic       si;
    logic       issue;
    logic [2:0] fifo_count;
    logic [3:0] shadow_q;

    int n_assert = 0;
    int n_fail   = 0;

    usr_cmd_sequencer #(.DEPTH(4), .TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_data   (cmd_data),
        .cmd_si     (cmd_si),
        .M          (m),
        .D          (d),
        .SI         (si),
        .issue      (issue),
        .fifo_count (fifo_count),
        .shadow_q   (shadow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] md, input logic [3:0] dt, input logic s);
        cmd_valid = v;
        cmd_mode  = md;
        cmd_data  = dt;
        cmd_si    = s;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 4'h0, 1'b0);
        cyc(2);
        // Edge numbering below is relative to this last reset edge (edge 0).
        chk("reset_count", 8'(fifo_count), 8'd0);
        chk("reset_issue", 8'(issue), 8'd0);
        chk("reset_bus", {1'b0, m, d, si}, 8'h00);
        chk("reset_shadow", 8'(shadow_q), 8'h0);
        chk("ready_in_reset", 8'(cmd_ready), 8'd0);

        rst = 1'b0;
        drive(1'b1, 2'b01, 4'b1011, 1'b0);
        #1;
        chk("ready_after_reset", 8'(cmd_ready), 8'd1);
        cyc(1);                                         // edge 1: accept load
        drive(1'b0, 2'b00, 4'h0, 1'b0);
        chk("load_count", 8'(fifo_count), 8'd1);
        cyc(2);                                         // edge 3
        chk("no_issue_before_tick", 8'(issue), 8'd0);
        cyc(1);                                         // edge 4: first tick
        chk("load_issue", 8'(issue), 8'd1);
        chk("load_bus", {1'b0, m, d, si}, {1'b0, 2'b01, 4'b1011, 1'b0});
        chk("load_pop_count", 8'(fifo_count), 8'd0);
        cyc(1);                                         // edge 5
        chk("load_shadow", 8'(shadow_q), 8'b1011);
        chk("load_issue_one_cycle", 8'(issue), 8'd0);

        // Sequence: A=01/1011, B=00, C=11/0, D=11/1, E=10, F=10
        drive(1'b1, 2'b01, 4'b1011, 1'b0);
        cyc(1);                                         // edge 6: A
        chk("seq_count_a", 8'(fifo_count), 8'd1);
        drive(1'b1, 2'b00, 4'h0, 1'b0);
        cyc(1);                                         // edge 7: B
        chk("seq_count_b", 8'(fifo_count), 8'd2);
        drive(1'b1, 2'b11, 4'h0, 1'b0);
        cyc(1);                                         // edge 8: push C, pop A
        chk("pushpop_count", 8'(fifo_count), 8'd2);
        chk("issue_a", 8'(issue), 8'd1);
        chk("bus_a", {1'b0, m, d, si}, {1'b0, 2'b01, 4'b1011, 1'b0});
        drive(1'b1, 2'b11, 4'h0, 1'b1);
        cyc(1);                                         // edge 9: D
        chk("shadow_a", 8'(shadow_q), 8'b1011);
        chk("seq_count_d", 8'(fifo_count), 8'd3);
        drive(1'b1, 2'b10, 4'h0, 1'b0);
        cyc(1);                                         // edge 10: E, FIFO full
        chk("full_count", 8'(fifo_count), 8'd4);
        chk("full_ready", 8'(cmd_ready), 8'd0);
        drive(1'b1, 2'b10, 4'h0, 1'b0);
        cyc(1);                                         // edge 11: F refused
        chk("full_reject_count", 8'(fifo_count), 8'd4);
        cyc(1);                                         // edge 12: pop B, F still refused
        chk("issue_b", 8'(issue), 8'd1);
        chk("bus_b", {1'b0, m, d, si}, 8'h00);
        chk("after_pop_count", 8'(fifo_count), 8'd3);
        cyc(1);                                         // edge 13: F accepted
        drive(1'b0, 2'b00, 4'h0, 1'b0);
        chk("accept_f_count", 8'(fifo_count), 8'd4);
        chk("shadow_b_hold", 8'(shadow_q), 8'b1011);
        cyc(3);                                         // edge 16: pop C
        chk("bus_c", {1'b0, m, d, si}, {1'b0, 2'b11, 4'h0, 1'b0});
        chk("issue_c", 8'(issue), 8'd1);
        cyc(1);
        chk("shadow_c", 8'(shadow_q), 8'b0101);
        cyc(3);                                         // edge 20: pop D
        chk("bus_d", {1'b0, m, d, si}, {1'b0, 2'b11, 4'h0, 1'b1});
        cyc(1);
        chk("shadow_d", 8'(shadow_q), 8'b1010);
        cyc(3);                                         // edge 24: pop E
        chk("bus_e", {1'b0, m, d, si}, {1'b0, 2'b10, 4'h0, 1'b0});
        cyc(1);
        chk("shadow_e", 8'(shadow_q), 8'b0101);
        cyc(3);                                         // edge 28: pop F
        chk("bus_f", {1'b0, m, d, si}, {1'b0, 2'b10, 4'h0, 1'b0});
        chk("drained_count", 8'(fifo_count), 8'd0);
        cyc(1);                                         // edge 29
        chk("shadow_f", 8'(shadow_q), 8'b1010);

        // Empty ticks leave the bus idle and shadow unchanged.
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("empty_issue", 8'(issue), 8'd0);
            chk("empty_bus", {1'b0, m, d, si}, 8'h00);
            chk("empty_shadow", 8'(shadow_q), 8'b1010);
        end                                             // now after edge 41

        cyc(3);                                         // edge 44: empty tick
        drive(1'b1, 2'b01, 4'b0110, 1'b0);
        cyc(1);                                         // edge 45
        drive(1'b1, 2'b10, 4'h0, 1'b0);
        cyc(1);                                         // edge 46
        drive(1'b1, 2'b11, 4'h0, 1'b1);
        cyc(1);                                         // edge 47
        drive(1'b0, 2'b00, 4'h0, 1'b0);
        chk("pre_reset_count", 8'(fifo_count), 8'd3);
        rst = 1'b1;
        cyc(1);                                         // edge 48: tick, but reset wins
        rst = 1'b0;
        chk("midrst_count", 8'(fifo_count), 8'd0);
        chk("midrst_shadow", 8'(shadow_q), 8'h0);
        chk("midrst_issue", 8'(issue), 8'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("no_stale_issue", 8'(issue), 8'd0);
            chk("no_stale_shadow", 8'(shadow_q), 8'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
